// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops bytes from a synchronous FIFO and sends them as UART 8N1
// frames (optionally with an even-parity bit) on a registered tx line.
module fifo_uart_tx #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 868,
    parameter int PARITY_EN    = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_data,
    output logic             fifo_ren,
    output logic             tx,
    output logic             busy,
    output logic             tx_done
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [BAUD_W-1:0]  r_baud_cnt;
    logic [BIT_W-1:0]   r_bit_cnt;
    logic [WIDTH-1:0]   r_shift;
    logic               r_parity;
    logic               r_tx;
    logic               r_tx_done;
    logic               w_tx_next;
    logic               w_baud_last;
    logic               w_baud_clr;

    assign w_baud_last = (r_baud_cnt == BAUD_LAST);

    // Pop only from IDLE with data available; reset blocks the pop so the
    // FIFO count never sees a read that this block will not consume.
    assign fifo_ren = (r_state == S_IDLE) && !fifo_empty && !rst;
    assign busy     = (r_state != S_IDLE);
    assign tx       = r_tx;
    assign tx_done  = r_tx_done;

    // The baud counter restarts on every state change and at every bit edge,
    // and stays parked at zero while no bit is on the line.
    assign w_baud_clr = (w_next != r_state) || w_baud_last ||
                        (r_state == S_IDLE) || (r_state == S_FETCH);

    // Next-state and line-level decode
    always_comb begin
        w_next    = r_state;
        w_tx_next = 1'b1;
        case (r_state)
            S_IDLE: begin
                if (fifo_ren) w_next = S_FETCH;
            end
            S_FETCH: begin
                w_next = S_START;
            end
            S_START: begin
                w_tx_next = 1'b0;
                if (w_baud_last) w_next = S_DATA;
            end
            S_DATA: begin
                w_tx_next = r_shift[0];
                if (w_baud_last && (r_bit_cnt == BIT_LAST))
                    w_next = (PARITY_EN != 0) ? S_PARITY : S_STOP;
            end
            S_PARITY: begin
                w_tx_next = r_parity;
                if (w_baud_last) w_next = S_STOP;
            end
            S_STOP: begin
                if (w_baud_last) w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // State, counters, data shift register and registered line outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_tx       <= 1'b1;
            r_tx_done  <= 1'b0;
            r_bit_cnt  <= '0;
            r_baud_cnt <= '0;
            r_shift    <= '0;
            r_parity   <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_tx      <= w_tx_next;
            r_tx_done <= (r_state == S_STOP) && w_baud_last;

            if (w_baud_clr) r_baud_cnt <= '0;
            else            r_baud_cnt <= r_baud_cnt + 1'b1;

            if (r_state == S_FETCH) begin
                r_shift  <= fifo_data;
                r_parity <= ^fifo_data;
            end

            if ((r_state == S_START) && w_baud_last)
                r_bit_cnt <= '0;

            if ((r_state == S_DATA) && w_baud_last) begin
                r_shift   <= r_shift >> 1;
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end
        end
    end

endmodule
